// File: rtl/loom_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loom_scan_pkg
//  Description : Shared types for the loom scan-chain controller. It holds the
//                host opcode and FSM state encodings and a width helper for
//                the in-word bit index.
//  Revision    : 1.0  initial release
// ============================================================================
package loom_scan_pkg;

    // Host opcodes carried on cmd_op_i
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_DUMP    = 2'd1,
        OP_RESTORE = 2'd2,
        OP_SWAP    = 2'd3
    } scan_op_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_PUSH   = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_e;

    // The in-word index needs at least one bit, even when a word is a single bit
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loom_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : loom_scan_ctrl_if
//  Description : Host-side bus of the scan controller: the command channel,
//                the dump word stream (controller -> host) and the restore
//                word stream (host -> controller). Signal suffixes give the
//                direction as seen from the controller.
//  Ports       : none (bundle only)
//                modport master : host side (drives cmd, rd_ready, wr_*)
//                modport slave  : controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface loom_scan_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    import loom_scan_pkg::*;

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    scan_op_e          cmd_op_i;

    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [WORD_W-1:0] rd_data_o;

    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [WORD_W-1:0] wr_data_i;

    modport master (
        output cmd_valid_i, cmd_op_i, rd_ready_i, wr_valid_i, wr_data_i,
        input  cmd_ready_o, rd_valid_o, rd_data_o, wr_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, rd_ready_i, wr_valid_i, wr_data_i,
        output cmd_ready_o, rd_valid_o, rd_data_o, wr_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/loom_scan_ctrl_word_sreg.sv
`default_nettype none
// ============================================================================
//  Module      : loom_scan_word_sreg
//  Description : WORD_W-bit right-shifting word register. Parallel load from
//                the restore stream; on each shift bit 0 leaves (feeding the
//                chain head) and the chain tail bit enters at the top, so the
//                same register both emits a restore word and captures a dump
//                word.
//  Ports       : clk_i, rst_ni    clock, async active-low reset
//                load_i/load_data_i  parallel load (wins over shift)
//                shift_i/ser_i    shift right, ser_i enters at bit WORD_W-1
//                ser_o            current bit 0
//                next_o           value the register takes on this edge
//  Revision    : 1.0  initial release
// ============================================================================
module loom_scan_word_sreg #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic              ser_i,
    output logic              ser_o,
    output logic [WORD_W-1:0] next_o
);

    logic [WORD_W-1:0] sreg_q;
    logic [WORD_W-1:0] sreg_d;
    logic [WORD_W-1:0] w_shifted;

    generate
        if (WORD_W == 1) begin : g_single
            assign w_shifted = ser_i;
        end else begin : g_multi
            assign w_shifted = {ser_i, sreg_q[WORD_W-1:1]};
        end
    endgenerate

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = load_data_i;
        end else if (shift_i) begin
            sreg_d = w_shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign ser_o  = sreg_q[0];
    assign next_o = sreg_d;

endmodule
`default_nettype wire

// File: rtl/loom_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : loom_scan_ctrl
//  Description : Scan-chain controller. On a host command it freezes the DUT
//                clock, shifts the whole chain once, dumps it as words,
//                restores it from words, or both (swap), then releases the
//                DUT clock.
//  Ports       : clk_i, rst_ni    clock, async active-low reset
//                bus (slave)      cmd / rd (dump) / wr (restore) streams
//                busy_o, done_o   status, done_o is a one-cycle pulse
//                dut_clk_en_o     DUT functional clock enable
//                scan_en_o        scan path select in the chain flops
//                scan_shift_o     chain advances one bit this cycle
//                scan_in_o        serial data to chain head
//                scan_out_i       serial data from chain tail
//  Revision    : 1.0  initial release
// ============================================================================
module loom_scan_ctrl
    import loom_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 24,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    loom_scan_ctrl_if.slave         bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    dut_clk_en_o,
    output logic                    scan_en_o,
    output logic                    scan_shift_o,
    output logic                    scan_in_o,
    input  logic                    scan_out_i
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = idx_width(WORD_W);

    scan_state_e        state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q;      // bits shifted so far in this pass
    logic [IDX_W-1:0]   idx_q;          // bit position within current word
    logic               dump_q;         // pass produces dump words
    logic               restore_q;      // pass consumes restore words
    logic [WORD_W-1:0]  rd_data_q;

    logic               w_accept;
    logic               w_last_in_word;
    logic               w_last_bit;
    logic               w_chain_end;
    logic               w_sreg_ser;
    logic [WORD_W-1:0]  w_sreg_next;
    logic [IDX_W-1:0]   w_align;

    assign w_accept       = (state_q == ST_IDLE) && bus.cmd_valid_i;
    assign w_last_in_word = (idx_q == IDX_W'(WORD_W - 1));
    assign w_last_bit     = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign w_chain_end    = (bit_cnt_q == CNT_W'(CHAIN_LEN));
    // A short final word sits in the upper bits of the shift register; move
    // it down so bit k is the k-th bit of the word and padding reads 0.
    assign w_align        = IDX_W'(WORD_W - 1) - idx_q;

    loom_scan_word_sreg #(
        .WORD_W (WORD_W)
    ) u_sreg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      ((state_q == ST_LOAD) && bus.wr_valid_i),
        .load_data_i (bus.wr_data_i),
        .shift_i     (state_q == ST_SHIFT),
        .ser_i       (scan_out_i),
        .ser_o       (w_sreg_ser),
        .next_o      (w_sreg_next)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_d = (bus.cmd_op_i == OP_NOP) ? ST_DONE : ST_FREEZE;
                end
            end
            ST_FREEZE: state_d = restore_q ? ST_LOAD : ST_SHIFT;
            ST_LOAD: begin
                if (bus.wr_valid_i) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_in_word || w_last_bit) begin
                    if (dump_q) begin
                        state_d = ST_PUSH;
                    end else if (w_last_bit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_PUSH: begin
                if (bus.rd_ready_i) begin
                    if (w_chain_end) begin
                        state_d = ST_DONE;
                    end else if (restore_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state so an asynchronous reset returns them
    // to their idle values immediately.
    always_comb begin
        bus.cmd_ready_o = (state_q == ST_IDLE);
        busy_o          = (state_q != ST_IDLE);
        done_o          = (state_q == ST_DONE);
        dut_clk_en_o    = !((state_q == ST_FREEZE) || (state_q == ST_LOAD) ||
                            (state_q == ST_SHIFT)  || (state_q == ST_PUSH));
        scan_en_o       = (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                          (state_q == ST_PUSH);
        scan_shift_o    = (state_q == ST_SHIFT);
        bus.rd_valid_o  = (state_q == ST_PUSH);
        bus.wr_ready_o  = (state_q == ST_LOAD);
        bus.rd_data_o   = rd_data_q;
        // Restore data comes from the word register. A pure dump recirculates
        // the live tail bit, so the bit leaving the chain re-enters on the
        // same shift edge and the chain ends the pass unchanged.
        scan_in_o       = restore_q ? w_sreg_ser
                                    : ((state_q == ST_SHIFT) && scan_out_i);
    end

    // Counters, opcode flags and dump word capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            dump_q    <= 1'b0;
            restore_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (w_accept) begin
                bit_cnt_q <= '0;
                idx_q     <= '0;
                dump_q    <= (bus.cmd_op_i == OP_DUMP) || (bus.cmd_op_i == OP_SWAP);
                restore_q <= (bus.cmd_op_i == OP_RESTORE) || (bus.cmd_op_i == OP_SWAP);
            end
            if (state_q == ST_SHIFT) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                idx_q     <= w_last_in_word ? '0 : idx_q + IDX_W'(1);
                if (dump_q && (w_last_in_word || w_last_bit)) begin
                    rd_data_q <= w_sreg_next >> w_align;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loom_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loom_scan_ctrl
//  Description : Directed bench for loom_scan_ctrl. Two instances (32-bit and
//                8-bit words) each drive a 24-bit chain model R where
//                scan_out_i = R[0] and a shift does R <= {scan_in_o, R[23:1]}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_loom_scan_ctrl;
    import loom_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    loom_scan_ctrl_if #(.WORD_W(32)) bus_a ();
    loom_scan_ctrl_if #(.WORD_W(8))  bus_b ();

    logic busy_a, done_a, clken_a, sen_a, sshift_a, sin_a, sout_a;
    logic busy_b, done_b, clken_b, sen_b, sshift_b, sin_b, sout_b;

    loom_scan_ctrl #(.CHAIN_LEN(24), .WORD_W(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a),
        .busy_o(busy_a), .done_o(done_a), .dut_clk_en_o(clken_a),
        .scan_en_o(sen_a), .scan_shift_o(sshift_a), .scan_in_o(sin_a),
        .scan_out_i(sout_a)
    );

    loom_scan_ctrl #(.CHAIN_LEN(24), .WORD_W(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b),
        .busy_o(busy_b), .done_o(done_b), .dut_clk_en_o(clken_b),
        .scan_en_o(sen_b), .scan_shift_o(sshift_b), .scan_in_o(sin_b),
        .scan_out_i(sout_b)
    );

    // Chain models
    logic [23:0] chain_a, chain_b, init_a, init_b;
    logic        ld_a, ld_b;
    int          shifts_a, shifts_b;

    assign sout_a = chain_a[0];
    assign sout_b = chain_b[0];

    always @(posedge clk) begin
        if (ld_a) begin
            chain_a  <= init_a;
            shifts_a <= 0;
        end else if (sshift_a) begin
            chain_a  <= {sin_a, chain_a[23:1]};
            shifts_a <= shifts_a + 1;
        end
        if (ld_b) begin
            chain_b  <= init_b;
            shifts_b <= 0;
        end else if (sshift_b) begin
            chain_b  <= {sin_b, chain_b[23:1]};
            shifts_b <= shifts_b + 1;
        end
    end

    task automatic load_chains(input logic [23:0] va, input logic [23:0] vb);
        @(negedge clk);
        init_a = va; init_b = vb; ld_a = 1'b1; ld_b = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    // Runs one command on instance A with always-ready host streams.
    // cyc is the cycle index (accept = 0) at which done_o is seen.
    task automatic run_a(input scan_op_e op, output int cyc, output int nwords,
                         output logic [31:0] word, output int first_wr);
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b1;
        bus_a.cmd_op_i    = op;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b0;
        cyc = 1; nwords = 0; word = '0; first_wr = -1;
        while (done_a !== 1'b1 && cyc < 100) begin
            if (bus_a.rd_valid_o === 1'b1) begin
                nwords++;
                word = bus_a.rd_data_o;
            end
            if (bus_a.wr_ready_o === 1'b1 && first_wr < 0) first_wr = cyc;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        logic [8:0] got;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        got = {bus_a.cmd_ready_o, busy_a, done_a, clken_a, sen_a, sshift_a,
               sin_a, bus_a.rd_valid_o, bus_a.wr_ready_o};
        total++;
        if (got !== 9'b1_0_0_1_0_0_0_0_0) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", got, 9'b100100000);
        end
        total++;
        if (bus_a.rd_data_o !== 32'h0) begin
            bad++; $display("FAIL reset_rd_data got=%h want=00000000", bus_a.rd_data_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus_a.cmd_ready_o !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got ready=%b busy=%b want ready=1 busy=0",
                            bus_a.cmd_ready_o, busy_a);
        end
    endtask

    task automatic test_dump;
        int cyc, nw, fw; logic [31:0] w;
        load_chains(24'h5AC3F0, 24'h0);
        bus_a.rd_ready_i = 1'b1; bus_a.wr_valid_i = 1'b0;
        run_a(OP_DUMP, cyc, nw, w, fw);
        total++; if (cyc !== 27) begin bad++; $display("FAIL dump_done_cycle got=%0d want=27", cyc); end
        total++; if (clken_a !== 1'b1) begin bad++; $display("FAIL dump_clken_at_done got=%b want=1", clken_a); end
        total++; if (nw !== 1) begin bad++; $display("FAIL dump_nwords got=%0d want=1", nw); end
        total++; if (w !== 32'h005AC3F0) begin bad++; $display("FAIL dump_word got=%h want=005ac3f0", w); end
        total++; if (shifts_a !== 24) begin bad++; $display("FAIL dump_shifts got=%0d want=24", shifts_a); end
        total++; if (chain_a !== 24'h5AC3F0) begin bad++; $display("FAIL dump_chain got=%h want=5ac3f0", chain_a); end
    endtask

    task automatic test_restore;
        int cyc, nw, fw; logic [31:0] w;
        load_chains(24'hA5A5A5, 24'h0);
        bus_a.rd_ready_i = 1'b1; bus_a.wr_valid_i = 1'b1; bus_a.wr_data_i = 32'hFF123456;
        run_a(OP_RESTORE, cyc, nw, w, fw);
        bus_a.wr_valid_i = 1'b0;
        total++; if (cyc !== 27) begin bad++; $display("FAIL restore_done_cycle got=%0d want=27", cyc); end
        total++; if (fw !== 2) begin bad++; $display("FAIL restore_load_cycle got=%0d want=2", fw); end
        total++; if (nw !== 0) begin bad++; $display("FAIL restore_rd_valid got=%0d want=0", nw); end
        total++; if (chain_a !== 24'h123456) begin bad++; $display("FAIL restore_chain got=%h want=123456", chain_a); end
    endtask

    task automatic test_swap;
        int cyc, nw, fw; logic [31:0] w;
        load_chains(24'h00CAFE, 24'h0);
        bus_a.rd_ready_i = 1'b1; bus_a.wr_valid_i = 1'b1; bus_a.wr_data_i = 32'h000BEEF1;
        run_a(OP_SWAP, cyc, nw, w, fw);
        bus_a.wr_valid_i = 1'b0;
        total++; if (cyc !== 28) begin bad++; $display("FAIL swap_done_cycle got=%0d want=28", cyc); end
        total++; if (w !== 32'h0000CAFE) begin bad++; $display("FAIL swap_word got=%h want=0000cafe", w); end
        total++; if (chain_a !== 24'h0BEEF1) begin bad++; $display("FAIL swap_chain got=%h want=0beef1", chain_a); end
    endtask

    task automatic test_backpressure;
        int cyc, stall;
        load_chains(24'h5AC3F0, 24'h0);
        bus_a.rd_ready_i = 1'b0; bus_a.wr_valid_i = 1'b0;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_op_i = OP_DUMP;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b0;
        cyc = 1; stall = 0;
        while (done_a !== 1'b1 && cyc < 100) begin
            if (bus_a.rd_valid_o === 1'b1) begin
                if (stall < 10) begin
                    total++;
                    if (bus_a.rd_data_o !== 32'h005AC3F0) begin
                        bad++; $display("FAIL bp_data cyc=%0d got=%h want=005ac3f0", cyc, bus_a.rd_data_o);
                    end
                    total++;
                    if (sshift_a !== 1'b0) begin
                        bad++; $display("FAIL bp_shift cyc=%0d got=%b want=0", cyc, sshift_a);
                    end
                    total++;
                    if (clken_a !== 1'b0) begin
                        bad++; $display("FAIL bp_clken cyc=%0d got=%b want=0", cyc, clken_a);
                    end
                    stall++;
                end else begin
                    bus_a.rd_ready_i = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus_a.rd_ready_i = 1'b1;
        total++; if (stall !== 10) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=10", stall); end
        total++; if (cyc !== 37) begin bad++; $display("FAIL bp_done_cycle got=%0d want=37", cyc); end
        total++; if (chain_a !== 24'h5AC3F0) begin bad++; $display("FAIL bp_chain got=%h want=5ac3f0", chain_a); end
    endtask

    task automatic test_word8;
        int cyc, nw;
        logic [7:0] words [3];
        load_chains(24'h0, 24'h5AC3F0);
        bus_b.rd_ready_i = 1'b1; bus_b.wr_valid_i = 1'b0;
        @(negedge clk);
        bus_b.cmd_valid_i = 1'b1; bus_b.cmd_op_i = OP_DUMP;
        @(negedge clk);
        bus_b.cmd_valid_i = 1'b0;
        cyc = 1; nw = 0;
        for (int i = 0; i < 3; i++) words[i] = 8'h00;
        while (done_b !== 1'b1 && cyc < 100) begin
            if (bus_b.rd_valid_o === 1'b1) begin
                if (nw < 3) words[nw] = bus_b.rd_data_o;
                nw++;
            end
            @(negedge clk);
            cyc++;
        end
        total++; if (nw !== 3) begin bad++; $display("FAIL w8_nwords got=%0d want=3", nw); end
        total++; if (words[0] !== 8'hF0) begin bad++; $display("FAIL w8_word0 got=%h want=f0", words[0]); end
        total++; if (words[1] !== 8'hC3) begin bad++; $display("FAIL w8_word1 got=%h want=c3", words[1]); end
        total++; if (words[2] !== 8'h5A) begin bad++; $display("FAIL w8_word2 got=%h want=5a", words[2]); end
        total++; if (cyc !== 29) begin bad++; $display("FAIL w8_done_cycle got=%0d want=29", cyc); end
        total++; if (chain_b !== 24'h5AC3F0) begin bad++; $display("FAIL w8_chain got=%h want=5ac3f0", chain_b); end
    endtask

    task automatic test_reset_mid;
        int cyc, nw, fw; logic [31:0] w;
        load_chains(24'h5AC3F0, 24'h0);
        bus_a.rd_ready_i = 1'b1; bus_a.wr_valid_i = 1'b0;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_op_i = OP_DUMP;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b0;
        repeat (9) @(negedge clk);            // now at cycle 10, inside SHIFT
        total++;
        if (sshift_a !== 1'b1) begin bad++; $display("FAIL mid_in_shift got=%b want=1", sshift_a); end
        rst_n = 1'b0;
        #1;
        total++; if (clken_a !== 1'b1) begin bad++; $display("FAIL mid_rst_clken got=%b want=1", clken_a); end
        total++; if (sen_a !== 1'b0) begin bad++; $display("FAIL mid_rst_scan_en got=%b want=0", sen_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
        load_chains(24'h5AC3F0, 24'h0);
        run_a(OP_DUMP, cyc, nw, w, fw);
        total++; if (cyc !== 27) begin bad++; $display("FAIL mid_redump_cycle got=%0d want=27", cyc); end
        total++; if (w !== 32'h005AC3F0) begin bad++; $display("FAIL mid_redump_word got=%h want=005ac3f0", w); end
        total++; if (chain_a !== 24'h5AC3F0) begin bad++; $display("FAIL mid_redump_chain got=%h want=5ac3f0", chain_a); end
    endtask

    task automatic test_nop;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b1; bus_a.cmd_op_i = OP_NOP;
        @(negedge clk);
        bus_a.cmd_valid_i = 1'b0;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL nop_done got=%b want=1", done_a); end
        total++; if (clken_a !== 1'b1) begin bad++; $display("FAIL nop_clken got=%b want=1", clken_a); end
        total++; if (sshift_a !== 1'b0) begin bad++; $display("FAIL nop_shift got=%b want=0", sshift_a); end
        @(negedge clk);
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL nop_done_pulse got=%b want=0", done_a); end
        total++; if (bus_a.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b want=1", bus_a.cmd_ready_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        ld_a = 1'b1; ld_b = 1'b1; init_a = '0; init_b = '0;
        bus_a.cmd_valid_i = 1'b0; bus_a.cmd_op_i = OP_NOP;
        bus_a.rd_ready_i = 1'b0; bus_a.wr_valid_i = 1'b0; bus_a.wr_data_i = '0;
        bus_b.cmd_valid_i = 1'b0; bus_b.cmd_op_i = OP_NOP;
        bus_b.rd_ready_i = 1'b0; bus_b.wr_valid_i = 1'b0; bus_b.wr_data_i = '0;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0;

        test_reset();
        test_dump();
        test_restore();
        test_swap();
        test_backpressure();
        test_word8();
        test_reset_mid();
        test_nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
